vga_rgb_pipe: RTL and testbench

Parametrised, pipelined pixel colour generator for the VGA path. It sits between the sync/counter block (Hcount, Vcount, video_on) and the DAC/pin outputs. It replaces the single-bit bright/dark mapping with:
- a writable colour palette,
- a test-pattern mode select,
- frame-synchronous blink,
- hardware blanking.

The output is registered with a fixed 2-pixel latency, so the sync outputs must be delayed by the same amount upstream.

---
 rtl/vga_rgb_pipe.sv | 156 +++++++++++++++
 tb/tb_vga_rgb_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rgb_pipe.sv
// Pipelined VGA pixel colour generator: writable palette, test patterns,
// frame-synchronous blink and hardware blanking with a fixed 2-pixel latency.
module vga_rgb_pipe #(
    parameter int RGB_W        = 8,
    parameter int IDX_W        = 2,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pxl_en,
    input  logic             video_on,
    input  logic [9:0]       Hcount,
    input  logic [9:0]       Vcount,
    input  logic [IDX_W-1:0] pxl_idx,
    input  logic [1:0]       mode,
    input  logic             blink_en,
    input  logic             pal_we,
    input  logic [IDX_W-1:0] pal_addr,
    input  logic [RGB_W-1:0] pal_wdata,
    output logic [RGB_W-1:0] rgb,
    output logic             rgb_valid,
    output logic             blink_phase
);

    localparam int PAL_N = 1 << IDX_W;
    localparam int FC_W  = $clog2(BLINK_FRAMES + 1);

    localparam logic [9:0]      H_LIM   = 10'(H_ACTIVE);
    localparam logic [9:0]      V_LIM   = 10'(V_ACTIVE);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        MODE_PAL  = 2'b00,
        MODE_BARS = 2'b01,
        MODE_GRID = 2'b10,
        MODE_INV  = 2'b11
    } mode_t;

    logic [RGB_W-1:0] pal [PAL_N];

    logic [FC_W-1:0]  frame_cnt;
    logic             frame_start;

    // Stage-1 state; active_s1 is the inverse of the blank flag so that the
    // all-zero reset value reads as "blank" and the first output stays invalid.
    logic             active_s1;
    mode_t            mode_s1;
    logic [IDX_W-1:0] sel_s1;
    logic             grid_s1;

    logic             blank_d;
    logic [IDX_W-1:0] sel_bar;
    logic [IDX_W-1:0] sel_d;
    logic             grid_d;
    logic [RGB_W-1:0] rgb_d;

    // Palette: written on any clk, independent of the pixel enable.
    // NOTE: the palette is a handful of flops, so it is reset to its defaults
    // with the rest of the state; a RAM-based palette could not be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal[i] <= (i == 0) ? '0 : '1;
            end
        end else if (pal_we) begin
            pal[pal_addr] <= pal_wdata;
        end
    end

    // 128-pixel colour bars: Hcount[9:7] fitted to the palette index width.
    generate
        if (IDX_W >= 3) begin : g_bar_ext
            assign sel_bar = IDX_W'(Hcount[9:7]);
        end else begin : g_bar_trunc
            assign sel_bar = Hcount[7 +: IDX_W];
        end
    endgenerate

    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and a latch is inferred.
    always_comb begin
        blank_d = ~video_on | (Hcount >= H_LIM) | (Vcount >= V_LIM);
        grid_d  = (Hcount[4:0] == 5'd0) || (Vcount[4:0] == 5'd0);
        sel_d   = pxl_idx;
        case (mode_t'(mode))
            MODE_BARS: sel_d = sel_bar;
            MODE_GRID: sel_d = '0;
            default: begin
                if (blink_en && blink_phase) begin
                    sel_d = '0;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_s1 <= 1'b0;
            mode_s1   <= MODE_PAL;
            sel_s1    <= '0;
            grid_s1   <= 1'b0;
        end else if (pxl_en) begin
            active_s1 <= ~blank_d;
            mode_s1   <= mode_t'(mode);
            sel_s1    <= sel_d;
            grid_s1   <= grid_d;
        end
    end

    always_comb begin
        rgb_d = '0;
        if (active_s1) begin
            case (mode_s1)
                MODE_PAL,
                MODE_BARS: rgb_d = pal[sel_s1];
                MODE_GRID: rgb_d = grid_s1 ? '1 : '0;
                MODE_INV:  rgb_d = ~pal[sel_s1];
                default:   rgb_d = '0;
            endcase
        end
    end

    // Palette read and write share an edge, so a same-cycle write is seen
    // only by the next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else if (pxl_en) begin
            rgb       <= rgb_d;
            rgb_valid <= active_s1;
        end
    end

    assign frame_start = pxl_en && (Hcount == 10'd0) && (Vcount == 10'd0);

    // The (0,0) pixel is captured on the same edge, so it sees the old phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_rgb_pipe.sv
// Directed bench for vga_rgb_pipe: per-pixel expected colours are carried one
// pixel behind the stimulus to line up with the 2-pixel output latency.
module tb_vga_rgb_pipe;

    localparam int RGB_W = 8;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pxl_en = 1'b0;
    logic             video_on = 1'b1;
    logic [9:0]       Hcount = 10'd0;
    logic [9:0]       Vcount = 10'd1;
    logic [IDX_W-1:0] pxl_idx = '0;
    logic [1:0]       mode = 2'b00;
    logic             blink_en = 1'b0;
    logic             pal_we = 1'b0;
    logic [IDX_W-1:0] pal_addr = '0;
    logic [RGB_W-1:0] pal_wdata = '0;

    logic [RGB_W-1:0] rgb, rgb1;
    logic             rgb_valid, rgb_valid1;
    logic             blink_phase, blink_phase1;

    int vectors = 0;
    int miscompares = 0;

    logic [RGB_W-1:0] prev_rgb = '0;
    logic             prev_valid = 1'b0;
    string            prev_tag = "rst_flush";
    logic [RGB_W-1:0] shown_rgb = '0;
    logic             shown_valid = 1'b0;

    always #5 clk = ~clk;

    vga_rgb_pipe #(.RGB_W(RGB_W), .IDX_W(IDX_W), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .pxl_en(pxl_en), .video_on(video_on),
        .Hcount(Hcount), .Vcount(Vcount), .pxl_idx(pxl_idx), .mode(mode),
        .blink_en(blink_en), .pal_we(pal_we), .pal_addr(pal_addr),
        .pal_wdata(pal_wdata), .rgb(rgb), .rgb_valid(rgb_valid),
        .blink_phase(blink_phase)
    );

    vga_rgb_pipe #(.RGB_W(RGB_W), .IDX_W(IDX_W), .BLINK_FRAMES(1)) dut1 (
        .clk(clk), .rst(rst), .pxl_en(pxl_en), .video_on(video_on),
        .Hcount(Hcount), .Vcount(Vcount), .pxl_idx(pxl_idx), .mode(mode),
        .blink_en(blink_en), .pal_we(pal_we), .pal_addr(pal_addr),
        .pal_wdata(pal_wdata), .rgb(rgb1), .rgb_valid(rgb_valid1),
        .blink_phase(blink_phase1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rgb(input string tag, input logic [RGB_W-1:0] er, input logic ev);
        vectors++;
        assert (rgb === er && rgb_valid === ev) else begin
            miscompares++;
            $error("FAIL %s: rgb=%h valid=%b, expected rgb=%h valid=%b", tag, rgb, rgb_valid, er, ev);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Drive one pixel, optionally preceded by `gap` disabled clocks during
    // which the output must hold; then check the pixel driven one call ago.
    task automatic px(input string tag, input logic [9:0] hc, input logic [9:0] vc,
                      input logic [IDX_W-1:0] idx, input int gap,
                      input logic [RGB_W-1:0] er, input logic ev);
        Hcount  = hc;
        Vcount  = vc;
        pxl_idx = idx;
        for (int i = 0; i < gap; i++) begin
            pxl_en = 1'b0;
            tick();
            check_rgb($sformatf("%s_hold%0d", tag, i), shown_rgb, shown_valid);
        end
        pxl_en = 1'b1;
        tick();
        check_rgb(prev_tag, prev_rgb, prev_valid);
        shown_rgb   = prev_rgb;
        shown_valid = prev_valid;
        prev_rgb    = er;
        prev_valid  = ev;
        prev_tag    = tag;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_rgb("reset_out", 8'h00, 1'b0);
        check_bit("reset_phase", blink_phase, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Default palette black/white
        px("t1_h0", 10'd0, 10'd1, 2'd0, 0, 8'h00, 1'b1);
        px("t1_h1", 10'd1, 10'd1, 2'd1, 0, 8'hFF, 1'b1);
        px("t1_h2", 10'd2, 10'd1, 2'd0, 0, 8'h00, 1'b1);
        px("t1_h3", 10'd3, 10'd1, 2'd1, 0, 8'hFF, 1'b1);

        // Read-before-write on a palette entry
        px("t2_old", 10'd10, 10'd1, 2'd1, 0, 8'hFF, 1'b1);
        pal_we = 1'b1; pal_addr = 2'd1; pal_wdata = 8'hE0;
        px("t2_new", 10'd11, 10'd1, 2'd1, 0, 8'hE0, 1'b1);
        pal_we = 1'b0;
        px("t2_h12", 10'd12, 10'd1, 2'd0, 0, 8'h00, 1'b1);

        // Palette writes while the pixel enable is low; output must hold
        pxl_en = 1'b0;
        pal_we = 1'b1; pal_addr = 2'd2; pal_wdata = 8'h1C;
        tick();
        check_rgb("pal_wr_hold0", shown_rgb, shown_valid);
        pal_addr = 2'd3; pal_wdata = 8'h03;
        tick();
        check_rgb("pal_wr_hold1", shown_rgb, shown_valid);
        pal_we = 1'b0;

        // Colour bars, including the wrap at Hcount = 512
        mode = 2'b01;
        px("t3_bar0", 10'd0,   10'd1, 2'd0, 0, 8'h00, 1'b1);
        px("t3_bar1", 10'd128, 10'd1, 2'd0, 0, 8'hE0, 1'b1);
        px("t3_bar2", 10'd256, 10'd1, 2'd0, 0, 8'h1C, 1'b1);
        px("t3_bar3", 10'd384, 10'd1, 2'd0, 0, 8'h03, 1'b1);
        px("t3_bar4", 10'd512, 10'd1, 2'd0, 0, 8'h00, 1'b1);
        // Inverted palette
        mode = 2'b11;
        px("t3_inv2", 10'd20, 10'd1, 2'd2, 0, 8'hE3, 1'b1);
        px("t3_inv0", 10'd21, 10'd1, 2'd0, 0, 8'hFF, 1'b1);
        // Grid
        mode = 2'b10;
        px("t3_grid_h32", 10'd32, 10'd5,  2'd0, 0, 8'hFF, 1'b1);
        px("t3_grid_off", 10'd33, 10'd5,  2'd0, 0, 8'h00, 1'b1);
        px("t3_grid_v32", 10'd33, 10'd32, 2'd0, 0, 8'hFF, 1'b1);
        px("t3_grid_h0",  10'd0,  10'd7,  2'd0, 0, 8'hFF, 1'b1);

        // Blanking
        mode = 2'b00;
        px("t4_h640", 10'd640, 10'd1, 2'd3, 0, 8'h00, 1'b0);
        px("t4_h799", 10'd799, 10'd1, 2'd3, 0, 8'h00, 1'b0);
        video_on = 1'b0;
        px("t4_vo0", 10'd5, 10'd1, 2'd3, 0, 8'h00, 1'b0);
        video_on = 1'b1;
        px("t4_v480", 10'd5, 10'd480, 2'd3, 0, 8'h00, 1'b0);
        px("t4_ok", 10'd5, 10'd1, 2'd3, 0, 8'h03, 1'b1);
        mode = 2'b01;
        px("t4_bar799", 10'd799, 10'd2, 2'd0, 0, 8'h00, 1'b0);
        mode = 2'b00;

        // Blink over four frame starts
        blink_en = 1'b1;
        px("t5_fs1", 10'd0, 10'd0, 2'd3, 0, 8'h03, 1'b1);
        check_bit("t5_phase_fs1", blink_phase, 1'b0);
        check_bit("t5_phase1_fs1", blink_phase1, 1'b1);
        px("t5_a", 10'd1, 10'd0, 2'd3, 0, 8'h03, 1'b1);
        px("t5_fs2", 10'd0, 10'd0, 2'd3, 0, 8'h03, 1'b1);
        check_bit("t5_phase_fs2", blink_phase, 1'b1);
        check_bit("t5_phase1_fs2", blink_phase1, 1'b0);
        px("t5_b", 10'd1, 10'd0, 2'd3, 0, 8'h00, 1'b1);
        mode = 2'b11;
        px("t5_inv", 10'd2, 10'd0, 2'd3, 0, 8'hFF, 1'b1);
        mode = 2'b00;
        blink_en = 1'b0;
        px("t5_noblink", 10'd3, 10'd0, 2'd3, 0, 8'h03, 1'b1);
        blink_en = 1'b1;
        px("t5_fs3", 10'd0, 10'd0, 2'd3, 0, 8'h00, 1'b1);
        check_bit("t5_phase_fs3", blink_phase, 1'b1);
        check_bit("t5_phase1_fs3", blink_phase1, 1'b1);
        px("t5_fs4", 10'd0, 10'd0, 2'd3, 0, 8'h00, 1'b1);
        check_bit("t5_phase_fs4", blink_phase, 1'b0);
        check_bit("t5_phase1_fs4", blink_phase1, 1'b0);
        px("t5_c", 10'd1, 10'd0, 2'd3, 0, 8'h03, 1'b1);
        blink_en = 1'b0;

        // Pixel enable every 4th clock
        px("t6_s0", 10'd40, 10'd1, 2'd1, 3, 8'hE0, 1'b1);
        px("t6_s1", 10'd41, 10'd1, 2'd2, 3, 8'h1C, 1'b1);
        px("t6_s2", 10'd42, 10'd1, 2'd1, 3, 8'hE0, 1'b1);
        px("t6_s3", 10'd43, 10'd1, 2'd0, 3, 8'h00, 1'b1);

        // (0,0) with the pixel enable low is not a frame start
        pxl_en = 1'b0;
        Hcount = 10'd0;
        Vcount = 10'd0;
        tick();
        tick();
        check_bit("t6_noframe_phase1", blink_phase1, 1'b0);
        check_rgb("t6_pre_rst", shown_rgb, shown_valid);

        // Asynchronous reset mid-line
        #2;
        rst = 1'b1;
        #1;
        check_rgb("t6_async_rst", 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_rgb = '0; prev_valid = 1'b0; prev_tag = "t6_rst_flush";
        shown_rgb = '0; shown_valid = 1'b0;

        // Palette defaults restored, first output invalid after one enable
        mode = 2'b01;
        px("t6_r_bar1", 10'd128, 10'd1, 2'd0, 1, 8'hFF, 1'b1);
        px("t6_r_bar2", 10'd256, 10'd1, 2'd0, 1, 8'hFF, 1'b1);
        px("t6_r_bar3", 10'd384, 10'd1, 2'd0, 0, 8'hFF, 1'b1);
        px("t6_r_bar0", 10'd0,   10'd1, 2'd0, 0, 8'h00, 1'b1);
        px("t6_tail",   10'd1,   10'd1, 2'd0, 0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
